// File: rtl/program_loader.sv
// Byte-stream program loader: big-endian word count, then big-endian words written to program RAM.
// Optional trailing XOR checksum byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int MEMORY_DEPTH  = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     p_ram_rw,
    output logic [ADDRESS_WIDTH-1:0] p_ram_address,
    output logic [DATA_WIDTH-1:0]    p_ram_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     cpu_enable,
    output logic [3:0]               fsm_state
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CHECKSUM_EN = 1'b1;
`else
    localparam bit CHECKSUM_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR
    } state_t;

    state_t      state;
    logic [15:0] count;
    logic [15:0] index;
    logic [7:0]  hi_byte;
    logic [7:0]  checksum;
    logic        xfer;

    // Handshake: a byte moves on a rising edge where byte_valid and byte_ready are both 1.
    assign xfer      = byte_valid && byte_ready;
    assign fsm_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            index         <= '0;
            hi_byte       <= '0;
            checksum      <= '0;
            byte_ready    <= 1'b0;
            p_ram_rw      <= 1'b0;
            p_ram_address <= '0;
            p_ram_data    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            cpu_enable    <= 1'b0;
        end else begin
            done     <= 1'b0;
            p_ram_rw <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state      <= LEN_HI;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        error      <= 1'b0;
                        cpu_enable <= 1'b0;
                        index      <= '0;
                        checksum   <= '0;
                    end else if (state == DONE) begin
                        state      <= IDLE;
                        cpu_enable <= 1'b1;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        hi_byte <= byte_data;
                        state   <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        count <= {hi_byte, byte_data};
                        if ({hi_byte, byte_data} > 16'(MEMORY_DEPTH)) begin
                            state      <= ERROR;
                            error      <= 1'b1;
                            busy       <= 1'b0;
                            byte_ready <= 1'b0;
                        end else if ({hi_byte, byte_data} == 16'd0) begin
                            if (CHECKSUM_EN) begin
                                state <= CHECK;
                            end else begin
                                state      <= DONE;
                                done       <= 1'b1;
                                busy       <= 1'b0;
                                byte_ready <= 1'b0;
                            end
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (xfer) begin
                        hi_byte  <= byte_data;
                        checksum <= checksum ^ byte_data;
                        state    <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (xfer) begin
                        checksum      <= checksum ^ byte_data;
                        p_ram_rw      <= 1'b1;
                        p_ram_address <= ADDRESS_WIDTH'(index);
                        p_ram_data    <= DATA_WIDTH'({hi_byte, byte_data});
                        byte_ready    <= 1'b0;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    index <= index + 16'd1;
                    if ((index + 16'd1) < count) begin
                        state      <= DATA_HI;
                        byte_ready <= 1'b1;
                    end else if (CHECKSUM_EN) begin
                        state      <= CHECK;
                        byte_ready <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                CHECK: begin
                    // Words already written stay in RAM whatever the checksum says.
                    if (xfer) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        if (byte_data == checksum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader; behaviour follows PROGRAM_LOADER_CHECKSUM_EN when defined.
module tb_program_loader;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 64;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [15:0] word_q_t[$];

    logic          clock = 1'b0;
    logic          reset, start, byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready, p_ram_rw, busy, done, error, cpu_enable;
    logic [AW-1:0] p_ram_address;
    logic [DW-1:0] p_ram_data;
    logic [3:0]    fsm_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          done_cnt, rw_ready_cnt;
    bit          timed_out, exp_error, exp_done;

    program_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .p_ram_rw(p_ram_rw),
        .p_ram_address(p_ram_address), .p_ram_data(p_ram_data), .busy(busy),
        .done(done), .error(error), .cpu_enable(cpu_enable), .fsm_state(fsm_state)
    );

    always #5 clock = ~clock;

    // Reference model: parses the byte stream directly into expected writes and outcome.
    function automatic void build_model(input byte_q_t s);
        int         n;
        logic [7:0] x;
        exp_q.delete();
        exp_error = 1'b0;
        exp_done  = 1'b0;
        x = 8'h00;
        n = int'({s[0], s[1]});
        if (n > DEPTH) begin
            exp_error = 1'b1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            exp_q.push_back({16'(w), s[2+2*w], s[3+2*w]});
            x = x ^ s[2+2*w] ^ s[3+2*w];
        end
        if (CK && s[2+2*n] != x) exp_error = 1'b1;
        else exp_done = 1'b1;
    endfunction

    task automatic make_stream(input word_q_t w, input bit bad, output byte_q_t s);
        logic [7:0] x;
        x = 8'h00;
        s.delete();
        s.push_back(8'(w.size() >> 8));
        s.push_back(8'(w.size()));
        foreach (w[k]) begin
            s.push_back(w[k][15:8]);
            s.push_back(w[k][7:0]);
            x = x ^ w[k][15:8] ^ w[k][7:0];
        end
        if (CK) s.push_back(bad ? ~x : x);
    endtask

    // Pulses start, then feeds bytes; records every write and done pulse seen at negedges.
    task automatic run_stream(input byte_q_t s, input bit toggle, input int reset_addr);
        int i;
        bit phase, xfer;
        i = 0;
        phase = 1'b1;
        obs_q.delete();
        done_cnt = 0;
        rw_ready_cnt = 0;
        timed_out = 1'b1;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (p_ram_rw) begin
                obs_q.push_back({16'(p_ram_address), 16'(p_ram_data)});
                if (byte_ready) rw_ready_cnt++;
                if (reset_addr >= 0 && int'(p_ram_address) == reset_addr) begin
                    reset = 1'b1;
                    byte_valid = 1'b0;
                    timed_out = 1'b0;
                    return;
                end
            end
            if (done) done_cnt++;
            if (i >= s.size() && !busy) begin
                timed_out = 1'b0;
                byte_valid = 1'b0;
                return;
            end
            phase = toggle ? ~phase : 1'b1;
            byte_valid = (i < s.size()) && phase;
            byte_data = (i < s.size()) ? s[i] : 8'h00;
            xfer = byte_valid && byte_ready;
            @(negedge clock);
            if (xfer) i++;
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({byte_ready, p_ram_rw, busy, done, error, cpu_enable} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {byte_ready, p_ram_rw, busy, done, error, cpu_enable});
        end
        n_checks++;
        if ({p_ram_address, p_ram_data} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h expected 0", {p_ram_address, p_ram_data});
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({byte_ready, busy, cpu_enable} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 000", {byte_ready, busy, cpu_enable});
        end
    endtask

    task automatic test_basic();
        byte_q_t s;
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        if (CK) s.push_back(8'h40);
        run_stream(s, 1'b0, -1);
        @(negedge clock);
        n_checks++;
        if (timed_out !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got 1 expected 0"); end
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++; $display("FAIL basic_write_count: got %0d expected 2", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0] !== 32'h0000_1234) begin
                n_fail++; $display("FAIL basic_write0: got %h expected 00001234", obs_q[0]);
            end
            n_checks++;
            if (obs_q[1] !== 32'h0001_ABCD) begin
                n_fail++; $display("FAIL basic_write1: got %h expected 0001abcd", obs_q[1]);
            end
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done: got %0d expected 1", done_cnt); end
        n_checks++;
        if ({cpu_enable, error, busy} !== 3'b100) begin
            n_fail++; $display("FAIL basic_final: got %b expected 100", {cpu_enable, error, busy});
        end
    endtask

    task automatic test_oversize();
        byte_q_t s;
        s = '{8'h00, 8'h41};
        run_stream(s, 1'b0, -1);
        @(negedge clock);
        n_checks++;
        if (timed_out !== 1'b0) begin n_fail++; $display("FAIL oversize_timeout: got 1 expected 0"); end
        n_checks++;
        if (obs_q.size() != 0 || done_cnt != 0) begin
            n_fail++; $display("FAIL oversize_activity: got %0d writes %0d done expected 0 0", obs_q.size(), done_cnt);
        end
        n_checks++;
        if ({error, cpu_enable, busy, byte_ready} !== 4'b1000) begin
            n_fail++; $display("FAIL oversize_final: got %b expected 1000", {error, cpu_enable, busy, byte_ready});
        end
    endtask

    task automatic test_zero();
        byte_q_t s;
        s = '{8'h00, 8'h00};
        if (CK) s.push_back(8'h00);
        run_stream(s, 1'b0, -1);
        @(negedge clock);
        n_checks++;
        if (timed_out !== 1'b0 || obs_q.size() != 0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL zero_count: got timeout=%0d writes=%0d done=%0d expected 0 0 1",
                     timed_out, obs_q.size(), done_cnt);
        end
        n_checks++;
        if ({cpu_enable, error} !== 2'b10) begin
            n_fail++; $display("FAIL zero_final: got %b expected 10", {cpu_enable, error});
        end
    endtask

    task automatic test_toggle();
        word_q_t w;
        byte_q_t s;
        for (int k = 0; k < 3; k++) w.push_back(16'($urandom));
        make_stream(w, 1'b0, s);
        build_model(s);
        run_stream(s, 1'b1, -1);
        @(negedge clock);
        n_checks++;
        if (timed_out !== 1'b0 || obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL toggle_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                n_checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    n_fail++; $display("FAIL toggle_write%0d: got %h expected %h", k, obs_q[k], exp_q[k]);
                end
            end
        end
        n_checks++;
        if (rw_ready_cnt != 0) begin
            n_fail++; $display("FAIL toggle_ready_in_write: got %0d expected 0", rw_ready_cnt);
        end
        n_checks++;
        if (cpu_enable !== 1'b1) begin n_fail++; $display("FAIL toggle_cpu_enable: got %b expected 1", cpu_enable); end
    endtask

    task automatic test_reset_mid_write();
        word_q_t w;
        byte_q_t s;
        for (int k = 0; k < 3; k++) w.push_back(16'($urandom));
        make_stream(w, 1'b0, s);
        build_model(s);
        run_stream(s, 1'b0, 1);
        @(negedge clock);
        n_checks++;
        if ({byte_ready, p_ram_rw, busy, done, error, cpu_enable, p_ram_address, p_ram_data} !== 38'h0) begin
            n_fail++;
            $display("FAIL midwrite_reset: got %b %h %h expected all zero",
                     {byte_ready, p_ram_rw, busy, done, error, cpu_enable}, p_ram_address, p_ram_data);
        end
        n_checks++;
        if (timed_out !== 1'b0 || obs_q.size() != 2) begin
            n_fail++; $display("FAIL midwrite_reached: got %0d writes expected 2", obs_q.size());
        end
        reset = 1'b0;
        run_stream(s, 1'b0, -1);
        @(negedge clock);
        n_checks++;
        if (timed_out !== 1'b0 || obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL reload_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                n_checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    n_fail++; $display("FAIL reload_write%0d: got %h expected %h", k, obs_q[k], exp_q[k]);
                end
            end
        end
    endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        byte_q_t s;
        s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
        run_stream(s, 1'b0, -1);
        @(negedge clock);
        n_checks++;
        if (timed_out !== 1'b0 || obs_q.size() != 1) begin
            n_fail++; $display("FAIL badck_count: got %0d writes expected 1", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0] !== 32'h0000_1234) begin
                n_fail++; $display("FAIL badck_write0: got %h expected 00001234", obs_q[0]);
            end
        end
        n_checks++;
        if ({error, cpu_enable, done_cnt != 0} !== 3'b100) begin
            n_fail++; $display("FAIL badck_final: got err=%b cpu=%b done=%0d expected 1 0 0", error, cpu_enable, done_cnt);
        end
    endtask
`endif

    task automatic test_random();
        word_q_t w;
        byte_q_t s;
        for (int it = 0; it < 6; it++) begin
            w.delete();
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) w.push_back(16'($urandom));
            make_stream(w, CK && ($urandom_range(0, 2) == 0), s);
            build_model(s);
            run_stream(s, $urandom_range(0, 1) == 1, -1);
            @(negedge clock);
            n_checks++;
            if (timed_out !== 1'b0 || obs_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL random%0d_count: got %0d writes expected %0d", it, obs_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[k]) begin
                    n_checks++;
                    if (obs_q[k] !== exp_q[k]) begin
                        n_fail++; $display("FAIL random%0d_write%0d: got %h expected %h", it, k, obs_q[k], exp_q[k]);
                    end
                end
            end
            n_checks++;
            if ({error, cpu_enable, done_cnt == 1} !== {exp_error, exp_done, exp_done}) begin
                n_fail++;
                $display("FAIL random%0d_outcome: got err=%b cpu=%b done=%0d expected err=%b cpu=%b",
                         it, error, cpu_enable, done_cnt, exp_error, exp_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_oversize();
        test_zero();
        test_toggle();
        test_reset_mid_write();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, program RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, program word width; only 16 supported (two bytes per word).
REQ-003 SHALL have parameter MEMORY_DEPTH, default 64, maximum loadable word count.
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin a load session; level-sampled.
REQ-007 SHALL have port byte_valid  input  1  byte_data is valid.
REQ-008 SHALL have port byte_data  input  8  incoming stream byte.
REQ-009 SHALL have port byte_ready  output  1  loader can accept a byte; a byte transfers on a cycle where byte_valid and byte_ready are both 1.
REQ-010 SHALL have port p_ram_rw  output  1  program RAM write strobe; 1 = write, 0 = read/idle.
REQ-011 SHALL have port p_ram_address  output  ADDRESS_WIDTH  program RAM word address.
REQ-012 SHALL have port p_ram_data  output  DATA_WIDTH  program RAM write data.
REQ-013 SHALL have port busy  output  1  session in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-015 SHALL have port error  output  1  sticky session failure.
REQ-016 SHALL have port cpu_enable  output  1  execution-driver release; high only after a successful load.

Function
REQ-017 SHALL implement the states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE and ERROR.
REQ-018 SHALL accept start in IDLE, DONE or ERROR: next state LEN_HI; clear error, cpu_enable and the word index. start SHALL be ignored in all other states.
REQ-019 SHALL use the stream format: count N (16-bit, big-endian, two bytes), then N words of two bytes each, high byte first.
REQ-020 SHALL drive byte_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK; each state advances only on a transfer.
REQ-021 SHALL, after LEN_LO, go to ERROR if N > MEMORY_DEPTH, to DONE (or CHECK) if N = 0, else to DATA_HI.
REQ-022 SHALL, after a transfer in DATA_LO on edge k, be in WRITE for exactly cycle k+1 with p_ram_rw=1, p_ram_address = word index (0..N-1) and p_ram_data = {hi, lo}; byte_ready SHALL be 0 in WRITE.
REQ-023 SHALL increment the word index after each WRITE; then go to DATA_HI if the index is below N, else to CHECK (macro defined) or DONE.
REQ-024 SHALL hold p_ram_rw=0 outside WRITE; p_ram_address and p_ram_data SHALL hold their last values.
REQ-025 SHALL make DONE last one cycle with done=1, then go to IDLE with cpu_enable=1, held until the next start or reset.
REQ-026 SHALL keep busy=1 in every state except IDLE, DONE and ERROR.
REQ-027 SHALL set error=1 in ERROR and keep it until start or reset; cpu_enable SHALL be 0 in ERROR.
REQ-028 SHALL, while stalled with byte_valid=0, hold state and all outputs indefinitely; there is no timeout.

Reset
REQ-029 SHALL, on reset=1 at a clock edge in any state (including mid-session or mid-WRITE), go to IDLE with byte_ready=0, p_ram_rw=0, p_ram_address=0, p_ram_data=0, busy=0, done=0, error=0, cpu_enable=0 and word index 0.
REQ-030 SHALL give reset priority over start and over any byte transfer in the same cycle.

Configuration
REQ-031 SHALL implement CHECK only when macro PROGRAM_LOADER_CHECKSUM_EN is defined: one trailing byte equal to the XOR of all 2N payload bytes (count bytes excluded).
REQ-032 SHALL, with the macro defined, go to DONE on a checksum match and to ERROR on a mismatch; words already written SHALL remain in RAM.
REQ-033 SHALL, without the macro, never enter CHECK; the stream ends after the last data byte.

Verification
REQ-034 SHALL cover: reset, start, stream 00 02 12 34 AB CD (+ checksum 40 if the macro is defined) -> writes 0x1234@0 and 0xABCD@1, one rw pulse each, done pulse, cpu_enable=1.
REQ-035 SHALL cover: count 00 41 with MEMORY_DEPTH=64 -> ERROR, error=1, no p_ram_rw pulse, cpu_enable=0.
REQ-036 SHALL cover: count 00 00 -> done after LEN_LO (after CHECK with checksum 00 if the macro is defined), no writes.
REQ-037 SHALL cover: byte_valid toggled 1/0 each cycle during a 3-word load -> identical RAM contents, byte_ready=0 in every WRITE cycle.
REQ-038 SHALL cover: reset asserted in the WRITE cycle of word 1 -> all outputs at reset values next cycle; a fresh start reloads from address 0.
REQ-039 SHALL cover (macro defined): stream 00 01 12 34 with a bad checksum 00 -> 0x1234 written at address 0, then error=1, cpu_enable=0.
